fs4_serial: RTL
===============

# fs4_serial

Bit-serial 4-bit full subtractor: the inverse of the team's combinational `fa4` adder. It accepts a minuend, a subtrahend and a borrow-in with a start pulse. It computes `a - b - c` one bit per clock, LSB first, through a single full-subtractor cell. It returns the difference and borrow-out with a one-cycle done strobe. It sits beside `fa4` in the arithmetic library as the area-minimal subtract path for multi-cycle datapaths.

## Interface
- `N`, 4, operand width; counter sized `$clog2(N)`, minimum 1 bit.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request; sampled only in IDLE.
- `a`  input  N  minuend, captured on the accepting edge.
- `b`  input  N  subtrahend, captured on the accepting edge.
- `c`  input  1  borrow-in, captured on the accepting edge.
- `s`  output  N  difference `(a - b - c) mod 2^N`; registered.
- `co`  output  1  borrow-out: 1 iff `a < b + c` (unsigned); registered.
- `busy`  output  1  high while an operation is in flight.
- `done`  output  1  one-cycle strobe; `s`/`co` are valid and newly updated.

## Operation
- States:
  - IDLE: `busy=0`, `done=0`.
  - SHIFT: `busy=1`, `done=0`.
  - DONE: `busy=0`, `done=1`.
- Reset (any time, asynchronous):
  - state = IDLE, bit counter = 0.
  - Internal operand shift registers and running borrow = 0.
  - `s=0`, `co=0`, `busy=0`, `done=0`.
  - An in-flight operation is discarded and produces no `done`.
- IDLE with `start=1` at an edge:
  - Load `a` and `b` into the shift registers and `c` into the running borrow.
  - Clear the counter; go to SHIFT.
- IDLE with `start=0`: stay in IDLE.
- SHIFT, per edge:
  - Bit i = counter.
  - `d_i = a_i ^ b_i ^ br`.
  - `br' = (~a_i & b_i) | (~a_i & br) | (b_i & br)`.
  - Shift `d_i` into the result register MSB-side, so after N shifts the LSB-first stream is aligned.
  - Increment the counter.
  - On the edge processing bit N-1: copy the assembled result to `s` and the final borrow to `co` (same edge), then go to DONE.
- DONE: on the next edge, go to IDLE unconditionally.
- `start` in SHIFT or DONE is ignored. Requests are not queued; the requester must hold or reissue `start` once `busy=0` and `done=0`.
- `s`/`co` change only on the completing edge or on reset. They hold their value across IDLE and through following operations until the next completion.
- Arithmetic is unsigned modulo 2^N. `co` is the borrow out of bit N-1. No overflow flag.

## Timing
- `start` accepted at edge k. Then:
  - `busy` is high from after edge k until edge k+N.
  - `s`/`co` update, and `done` rises, at edge k+N.
  - `done` falls at edge k+N+1.
- For N=4, latency from the accepting edge to `done` is 4 cycles.
- Back-to-back issue: the earliest next accept is edge k+N+2, giving a throughput of one operation per N+2 cycles.
- `start` held high continuously re-triggers at every IDLE.
- `a`/`b`/`c` are don't-care except at the accepting edge. Changing them mid-operation has no effect.
- If reset deasserts while `start` is high, the first accepting edge is the first rising edge after deassertion.

## Test plan
- Reset then idle: assert `rst` for 3 cycles with `start=0`. Outputs must read `s=0`, `co=0`, `busy=0`, `done=0`, and stay there for 10 cycles.
- Basic and borrow cases, one per operation, each checked at `done`:
  - `a=5, b=3, c=0` → `s=2, co=0`.
  - `a=3, b=5, c=0` → `s=14, co=1`.
  - `a=0, b=0, c=1` → `s=15, co=1`.
  - `a=15, b=15, c=1` → `s=15, co=1`.
  - `a=8, b=0, c=0` → `s=8, co=0`.
  - In each case `done` is high exactly 4 cycles after the accepting edge, for exactly 1 cycle.
- Exhaustive sweep: all 512 combinations of `a`, `b`, `c`. Each must match the reference model `{co, s} = {1'b0, a} - {1'b0, b} - c` (N+1-bit difference; `co` is its MSB).
- Ignored start and operand changes:
  - Accept `a=9, b=4, c=0`.
  - Pulse `start` with `a=1, b=2` in SHIFT cycle 2 and in the DONE cycle.
  - Toggle `a`/`b` mid-SHIFT.
  - Required: a single `done`, with `s=5, co=0`, and no second operation.
- Reset mid-operation:
  - Accept `a=2, b=7`.
  - Assert `rst` asynchronously (not on a clock edge) in SHIFT cycle 2.
  - Required: all outputs 0 immediately, and no `done` after release.
  - A new operation `a=7, b=2` must then give `s=5, co=0`.
- Back-to-back: hold `start=1` over three operand sets. Accepts must be spaced exactly 6 cycles apart. `s`/`co` must hold between completions.

Source files
------------

// File: rtl/fs4_serial_if.sv
// Request/response bundle for the bit-serial 4-bit subtractor.
interface fs4_serial_if #(
  parameter int unsigned N = 4
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         c;
  logic [N-1:0] s;
  logic         co;
  logic         busy;
  logic         done;

  // Requester side: drives operands and start, observes the result.
  modport master (
    output start, a, b, c,
    input  s, co, busy, done
  );

  // Subtractor side.
  modport slave (
    input  start, a, b, c,
    output s, co, busy, done
  );
endinterface

// File: rtl/fs4_serial.sv
// Bit-serial N-bit full subtractor: a - b - c, one bit per clock, LSB first,
// through a single full-subtractor cell. Result and borrow-out are registered
// and announced with a one-cycle done strobe.
module fs4_serial #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  fs4_serial_if.slave  bus
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [N-1:0]  a_sh;
  logic [N-1:0]  b_sh;
  logic [N-1:0]  res;
  logic          br;

  logic          load;
  logic          step;
  logic          last;
  logic          busy_nxt;
  logic          done_nxt;

  logic          a_i;
  logic          b_i;
  logic          d_i;
  logic          br_nxt;
  logic [N-1:0]  res_nxt;

  // Single full-subtractor cell on the bit selected by the counter.
  always_comb begin
    a_i     = a_sh[cnt];
    b_i     = b_sh[cnt];
    d_i     = a_i ^ b_i ^ br;
    br_nxt  = (~a_i & b_i) | (~a_i & br) | (b_i & br);
    res_nxt = {d_i, res[N-1:1]};
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          busy_nxt  = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        step     = 1'b1;
        busy_nxt = 1'b1;
        if (cnt == LAST_BIT) begin
          last      = 1'b1;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register with registered busy/done strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state    <= state_nxt;
      bus.busy <= busy_nxt;
      bus.done <= done_nxt;
    end
  end

  // Operand capture, serial shift and result publication on the final bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      br     <= 1'b0;
      res    <= '0;
      bus.s  <= '0;
      bus.co <= 1'b0;
    end else if (load) begin
      a_sh <= bus.a;
      b_sh <= bus.b;
      br   <= bus.c;
      cnt  <= '0;
    end else if (step) begin
      res <= res_nxt;
      br  <= br_nxt;
      cnt <= cnt + CW'(1);
      if (last) begin
        bus.s  <= res_nxt;
        bus.co <= br_nxt;
      end
    end
  end

endmodule
